// File: rtl/otter_mem_pkg.sv
// Shared types and lane helpers for the OTTER memory stage.
package otter_mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } ms_state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Size code 3 is treated as a word, the same as SZ_WORD.
    function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << addr_lo;
            SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/load_align_unit.sv
// Picks the addressed byte/half out of a read word and sign/zero-extends it.
// Purely combinational; no backpressure.
module load_align_unit
    import otter_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SZ_BYTE: data = {{24{sign & byte_v[7]}}, byte_v};
            SZ_HALF: data = {{16{sign & half_v[15]}}, half_v};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/memory_access_stage.sv
// OTTER MEM stage: req/ack data-memory access with lane steering, watchdog; MS_MISALIGN_TRAP_EN adds misalign trap.
// Latency: 1 cycle for non-memory ops, >= 2 cycles for loads/stores (accept, then ack).
// Backpressure: MS_STALL holds EXEC_* upstream from accept until the ack (or timeout) cycle.
module memory_access_stage
    import otter_mem_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 4
) (
    input  logic        MEMORY_CLOCK,
    input  logic        MEMORY_RESET,
    input  logic        EXEC_VALID,
    input  logic [31:0] EXEC_PC_4,
    input  logic [31:0] EXEC_ALU_RESULT,
    input  logic [31:0] EXEC_RS2,
    input  logic [1:0]  EXEC_RF_WR_SEL,
    input  logic        EXEC_REGWRITE,
    input  logic        EXEC_MEMWRITE,
    input  logic        EXEC_MEMREAD2,
    input  logic [1:0]  EXEC_SIZE,
    input  logic        EXEC_SIGN,
    input  logic [4:0]  EX_MS_RD,
    output logic        DM_REQ,
    output logic        DM_WE,
    output logic [31:0] DM_ADDR,
    output logic [31:0] DM_WDATA,
    output logic [3:0]  DM_BE,
    input  logic        DM_ACK,
    input  logic [31:0] DM_RDATA,
    output logic        MS_STALL,
    output logic        MS_VALID,
    output logic [31:0] MS_PC_4,
    output logic [31:0] MS_ALU_RESULT,
    output logic [31:0] MS_LOAD_DATA,
    output logic [1:0]  MS_RF_WR_SEL,
    output logic        MS_REGWRITE,
    output logic [4:0]  MS_RD,
    output logic        MS_ERR
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    ms_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             is_mem, accept, misalign, timeout;
    logic [31:0]      wdata_nxt;
    logic [31:0]      align_data;

    logic [1:0]       cap_size;
    logic [1:0]       cap_lo;
    logic             cap_sign;
    logic             cap_load;
    logic [31:0]      cap_pc4;
    logic [31:0]      cap_alu;
    logic [1:0]       cap_wr_sel;
    logic             cap_regwrite;
    logic [4:0]       cap_rd;

    always_comb begin
        is_mem = EXEC_MEMWRITE | EXEC_MEMREAD2;
        accept = (state == IDLE) & EXEC_VALID & is_mem;
`ifdef MS_MISALIGN_TRAP_EN
        misalign = ((EXEC_SIZE == SZ_HALF) & EXEC_ALU_RESULT[0]) |
                   (EXEC_SIZE[1] & (EXEC_ALU_RESULT[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        timeout  = (MAX_WAIT != 0) & (state == WAIT) & (cnt == CNT_LAST) & ~DM_ACK;
        // A trapped misaligned access completes in one cycle, so it must not stall.
        MS_STALL = (accept & ~misalign) | ((state == WAIT) & ~DM_ACK & ~timeout);

        case (EXEC_SIZE)
            SZ_BYTE: wdata_nxt = {4{EXEC_RS2[7:0]}};
            SZ_HALF: wdata_nxt = {2{EXEC_RS2[15:0]}};
            default: wdata_nxt = EXEC_RS2;
        endcase

        state_nxt = state;
        case (state)
            IDLE:    if (accept & ~misalign) state_nxt = WAIT;
            WAIT:    if (DM_ACK | timeout)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    load_align_unit u_align (
        .rdata   (DM_RDATA),
        .addr_lo (cap_lo),
        .size    (cap_size),
        .sign    (cap_sign),
        .data    (align_data)
    );

    always_ff @(posedge MEMORY_CLOCK) begin
        if (MEMORY_RESET) begin
            state         <= IDLE;
            cnt           <= '0;
            DM_REQ        <= 1'b0;
            DM_WE         <= 1'b0;
            DM_ADDR       <= '0;
            DM_WDATA      <= '0;
            DM_BE         <= '0;
            MS_VALID      <= 1'b0;
            MS_ERR        <= 1'b0;
            MS_PC_4       <= '0;
            MS_ALU_RESULT <= '0;
            MS_LOAD_DATA  <= '0;
            MS_RF_WR_SEL  <= '0;
            MS_REGWRITE   <= 1'b0;
            MS_RD         <= '0;
            cap_size      <= '0;
            cap_lo        <= '0;
            cap_sign      <= 1'b0;
            cap_load      <= 1'b0;
            cap_pc4       <= '0;
            cap_alu       <= '0;
            cap_wr_sel    <= '0;
            cap_regwrite  <= 1'b0;
            cap_rd        <= '0;
        end else begin
            state    <= state_nxt;
            MS_VALID <= 1'b0;
            MS_ERR   <= 1'b0;
            case (state)
                IDLE: begin
                    if (EXEC_VALID & (~is_mem | misalign)) begin
                        MS_VALID      <= 1'b1;
                        MS_ERR        <= misalign;
                        MS_PC_4       <= EXEC_PC_4;
                        MS_ALU_RESULT <= EXEC_ALU_RESULT;
                        MS_LOAD_DATA  <= '0;
                        MS_RF_WR_SEL  <= EXEC_RF_WR_SEL;
                        MS_REGWRITE   <= EXEC_REGWRITE & ~misalign;
                        MS_RD         <= EX_MS_RD;
                    end else if (accept) begin
                        DM_REQ       <= 1'b1;
                        DM_WE        <= EXEC_MEMWRITE;
                        DM_ADDR      <= {EXEC_ALU_RESULT[31:2], 2'b00};
                        DM_WDATA     <= wdata_nxt;
                        DM_BE        <= be_gen(EXEC_SIZE, EXEC_ALU_RESULT[1:0]);
                        cnt          <= '0;
                        cap_size     <= EXEC_SIZE;
                        cap_lo       <= EXEC_ALU_RESULT[1:0];
                        cap_sign     <= EXEC_SIGN;
                        cap_load     <= ~EXEC_MEMWRITE;
                        cap_pc4      <= EXEC_PC_4;
                        cap_alu      <= EXEC_ALU_RESULT;
                        cap_wr_sel   <= EXEC_RF_WR_SEL;
                        cap_regwrite <= EXEC_REGWRITE;
                        cap_rd       <= EX_MS_RD;
                    end
                end
                WAIT: begin
                    if (DM_ACK | timeout) begin
                        DM_REQ        <= 1'b0;
                        DM_WE         <= 1'b0;
                        MS_VALID      <= 1'b1;
                        MS_ERR        <= ~DM_ACK;
                        MS_PC_4       <= cap_pc4;
                        MS_ALU_RESULT <= cap_alu;
                        MS_LOAD_DATA  <= (DM_ACK & cap_load) ? align_data : 32'd0;
                        MS_RF_WR_SEL  <= cap_wr_sel;
                        MS_REGWRITE   <= cap_regwrite & DM_ACK;
                        MS_RD         <= cap_rd;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed self-checking bench for memory_access_stage (MAX_WAIT=15).
module tb_memory_access_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        exec_valid;
    logic [31:0] exec_pc_4, exec_alu, exec_rs2;
    logic [1:0]  exec_wr_sel, exec_size;
    logic        exec_regwrite, exec_memwrite, exec_memread, exec_sign;
    logic [4:0]  exec_rd;
    logic        dm_req, dm_we, dm_ack;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        ms_stall, ms_valid, ms_regwrite, ms_err;
    logic [31:0] ms_pc_4, ms_alu, ms_load;
    logic [1:0]  ms_wr_sel;
    logic [4:0]  ms_rd;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    memory_access_stage dut (
        .MEMORY_CLOCK(clk), .MEMORY_RESET(rst),
        .EXEC_VALID(exec_valid), .EXEC_PC_4(exec_pc_4), .EXEC_ALU_RESULT(exec_alu),
        .EXEC_RS2(exec_rs2), .EXEC_RF_WR_SEL(exec_wr_sel), .EXEC_REGWRITE(exec_regwrite),
        .EXEC_MEMWRITE(exec_memwrite), .EXEC_MEMREAD2(exec_memread), .EXEC_SIZE(exec_size),
        .EXEC_SIGN(exec_sign), .EX_MS_RD(exec_rd),
        .DM_REQ(dm_req), .DM_WE(dm_we), .DM_ADDR(dm_addr), .DM_WDATA(dm_wdata), .DM_BE(dm_be),
        .DM_ACK(dm_ack), .DM_RDATA(dm_rdata),
        .MS_STALL(ms_stall), .MS_VALID(ms_valid), .MS_PC_4(ms_pc_4), .MS_ALU_RESULT(ms_alu),
        .MS_LOAD_DATA(ms_load), .MS_RF_WR_SEL(ms_wr_sel), .MS_REGWRITE(ms_regwrite),
        .MS_RD(ms_rd), .MS_ERR(ms_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic mw, input logic mr, input logic [31:0] addr,
                            input logic [31:0] rs2, input logic [1:0] size, input logic sign,
                            input logic [4:0] rd, input logic rw);
        exec_valid    = 1'b1;
        exec_memwrite = mw;
        exec_memread  = mr;
        exec_alu      = addr;
        exec_rs2      = rs2;
        exec_size     = size;
        exec_sign     = sign;
        exec_rd       = rd;
        exec_regwrite = rw;
        exec_pc_4     = addr + 32'h1000;
        exec_wr_sel   = 2'd2;
    endtask

    task automatic test_reset();
        rst = 1'b1; exec_valid = 1'b0; exec_memwrite = 1'b0; exec_memread = 1'b0;
        exec_alu = 32'hDEAD; exec_rs2 = '0; exec_size = '0; exec_sign = 1'b0;
        exec_rd = '0; exec_regwrite = 1'b0; exec_pc_4 = '0; exec_wr_sel = '0;
        dm_ack = 1'b0; dm_rdata = '0;
        tick(); tick();
        tests++; if (dm_req !== 1'b0) begin fails++; $display("FAIL reset_dm_req got=%b exp=0", dm_req); end
        tests++; if ({ms_valid, ms_err, ms_regwrite} !== 3'b000) begin fails++; $display("FAIL reset_flags got=%b exp=000", {ms_valid, ms_err, ms_regwrite}); end
        tests++; if ({ms_alu, ms_load, dm_addr, dm_wdata} !== 128'd0) begin fails++; $display("FAIL reset_buses alu=%h load=%h addr=%h wdata=%h exp=0", ms_alu, ms_load, dm_addr, dm_wdata); end
        tests++; if (ms_stall !== 1'b0) begin fails++; $display("FAIL reset_stall got=%b exp=0", ms_stall); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_nonmem();
        drive_op(1'b0, 1'b0, 32'h1234, 32'h0, 2'd2, 1'b0, 5'd5, 1'b1);
        #1;
        tests++; if (ms_stall !== 1'b0) begin fails++; $display("FAIL nonmem_stall got=%b exp=0", ms_stall); end
        tick();
        exec_valid = 1'b0;
        tests++; if ({ms_valid, ms_err, ms_regwrite} !== 3'b101) begin fails++; $display("FAIL nonmem_flags got=%b exp=101", {ms_valid, ms_err, ms_regwrite}); end
        tests++; if (ms_alu !== 32'h1234 || ms_rd !== 5'd5 || ms_pc_4 !== 32'h2234 || ms_load !== 32'd0) begin
            fails++; $display("FAIL nonmem_data alu=%h rd=%0d pc4=%h load=%h exp 1234/5/2234/0", ms_alu, ms_rd, ms_pc_4, ms_load); end
        tick();
        tests++; if (ms_valid !== 1'b0 || ms_alu !== 32'h1234) begin fails++; $display("FAIL nonmem_idle_hold valid=%b alu=%h exp 0/1234", ms_valid, ms_alu); end
    endtask

    task automatic test_store_byte();
        int stall_cycles = 0;
        drive_op(1'b1, 1'b0, 32'h103, 32'hAABBCCDD, 2'd0, 1'b0, 5'd0, 1'b0);
        #1;
        if (ms_stall === 1'b1) stall_cycles++;
        tick();
        tests++; if (dm_req !== 1'b1 || dm_we !== 1'b1 || dm_addr !== 32'h100 || dm_be !== 4'b1000 || dm_wdata !== 32'hDDDDDDDD) begin
            fails++; $display("FAIL stb_req req=%b we=%b addr=%h be=%b wdata=%h exp 1/1/100/1000/dddddddd", dm_req, dm_we, dm_addr, dm_be, dm_wdata); end
        for (int i = 0; i < 2; i++) begin
            if (ms_stall === 1'b1) stall_cycles++;
            tick();
        end
        tests++; if (dm_req !== 1'b1 || dm_addr !== 32'h100 || ms_valid !== 1'b0) begin fails++; $display("FAIL stb_hold req=%b addr=%h valid=%b exp 1/100/0", dm_req, dm_addr, ms_valid); end
        dm_ack = 1'b1;
        #1;
        tests++; if (ms_stall !== 1'b0) begin fails++; $display("FAIL stb_ack_stall got=%b exp=0", ms_stall); end
        tests++; if (stall_cycles != 3) begin fails++; $display("FAIL stb_stall_cycles got=%0d exp=3", stall_cycles); end
        tick();
        dm_ack = 1'b0; exec_valid = 1'b0;
        tests++; if (dm_req !== 1'b0 || ms_valid !== 1'b1 || ms_err !== 1'b0 || ms_load !== 32'd0 || ms_alu !== 32'h103) begin
            fails++; $display("FAIL stb_done req=%b valid=%b err=%b load=%h alu=%h exp 0/1/0/0/103", dm_req, ms_valid, ms_err, ms_load, ms_alu); end
        tick();
        tests++; if (ms_valid !== 1'b0) begin fails++; $display("FAIL stb_one_pulse got=%b exp=0", ms_valid); end
    endtask

    task automatic test_store_half_both();
        drive_op(1'b1, 1'b1, 32'h006, 32'h12345678, 2'd1, 1'b0, 5'd3, 1'b0);
        tick();
        tests++; if (dm_we !== 1'b1 || dm_addr !== 32'h004 || dm_be !== 4'b1100 || dm_wdata !== 32'h56785678) begin
            fails++; $display("FAIL sth_req we=%b addr=%h be=%b wdata=%h exp 1/004/1100/56785678", dm_we, dm_addr, dm_be, dm_wdata); end
        dm_ack = 1'b1; dm_rdata = 32'hFFFFFFFF;
        tick();
        dm_ack = 1'b0; exec_valid = 1'b0;
        tests++; if (ms_valid !== 1'b1 || ms_load !== 32'd0) begin fails++; $display("FAIL sth_done valid=%b load=%h exp 1/0", ms_valid, ms_load); end
        tick();
    endtask

    task automatic test_load(input string name, input logic [31:0] addr, input logic [1:0] size,
                             input logic sign, input logic [31:0] rdata, input logic [3:0] exp_be,
                             input logic [31:0] exp_data);
        drive_op(1'b0, 1'b1, addr, 32'h0, size, sign, 5'd7, 1'b1);
        tick();
        tests++; if (dm_req !== 1'b1 || dm_we !== 1'b0 || dm_be !== exp_be || dm_addr !== {addr[31:2], 2'b00}) begin
            fails++; $display("FAIL %s_req req=%b we=%b be=%b addr=%h exp 1/0/%b/%h", name, dm_req, dm_we, dm_be, dm_addr, exp_be, {addr[31:2], 2'b00}); end
        dm_ack = 1'b1; dm_rdata = rdata;
        tick();
        dm_ack = 1'b0; dm_rdata = 32'h0; exec_valid = 1'b0;
        tests++; if (ms_valid !== 1'b1 || ms_load !== exp_data || ms_regwrite !== 1'b1 || ms_rd !== 5'd7 || ms_alu !== addr) begin
            fails++; $display("FAIL %s_data valid=%b load=%h rw=%b rd=%0d alu=%h exp 1/%h/1/7/%h", name, ms_valid, ms_load, ms_regwrite, ms_rd, ms_alu, exp_data, addr); end
        tick();
    endtask

    task automatic test_timeout();
        int n = 0;
        drive_op(1'b0, 1'b1, 32'h300, 32'h0, 2'd2, 1'b0, 5'd9, 1'b1);
        tick();
        while (dm_req === 1'b1 && n < 40) begin
            n++;
            if (n == 1) begin
                tests++; if (ms_stall !== 1'b1) begin fails++; $display("FAIL to_stall_first got=%b exp=1", ms_stall); end
            end
            if (n == 15) begin
                tests++; if (ms_stall !== 1'b0) begin fails++; $display("FAIL to_stall_last got=%b exp=0", ms_stall); end
            end
            tick();
        end
        tests++; if (n != 15) begin fails++; $display("FAIL to_req_cycles got=%0d exp=15", n); end
        tests++; if ({ms_valid, ms_err, ms_regwrite} !== 3'b110) begin fails++; $display("FAIL to_flags got=%b exp=110", {ms_valid, ms_err, ms_regwrite}); end
        drive_op(1'b0, 1'b0, 32'h55, 32'h0, 2'd2, 1'b0, 5'd1, 1'b1);
        tick();
        exec_valid = 1'b0;
        tests++; if ({ms_valid, ms_err, ms_regwrite} !== 3'b101 || ms_alu !== 32'h55) begin
            fails++; $display("FAIL to_next flags=%b alu=%h exp 101/55", {ms_valid, ms_err, ms_regwrite}, ms_alu); end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        drive_op(1'b1, 1'b0, 32'h400, 32'hCAFEF00D, 2'd2, 1'b0, 5'd2, 1'b0);
        tick();
        tick();
        rst = 1'b1; exec_valid = 1'b0;
        tick();
        rst = 1'b0;
        tests++; if (dm_req !== 1'b0 || ms_valid !== 1'b0) begin fails++; $display("FAIL rstw_drop req=%b valid=%b exp 0/0", dm_req, ms_valid); end
        dm_ack = 1'b1;
        tick();
        dm_ack = 1'b0;
        tests++; if (dm_req !== 1'b0 || ms_valid !== 1'b0 || ms_err !== 1'b0) begin fails++; $display("FAIL rstw_late_ack req=%b valid=%b err=%b exp 0/0/0", dm_req, ms_valid, ms_err); end
        tick();
    endtask

    task automatic test_misalign();
        drive_op(1'b0, 1'b1, 32'h101, 32'h0, 2'd2, 1'b0, 5'd4, 1'b1);
`ifdef MS_MISALIGN_TRAP_EN
        tick();
        exec_valid = 1'b0;
        tests++; if (dm_req !== 1'b0 || {ms_valid, ms_err, ms_regwrite} !== 3'b110) begin
            fails++; $display("FAIL mis_trap req=%b flags=%b exp 0/110", dm_req, {ms_valid, ms_err, ms_regwrite}); end
        tick();
`else
        tick();
        tests++; if (dm_req !== 1'b1 || dm_addr !== 32'h100 || dm_be !== 4'hF) begin
            fails++; $display("FAIL mis_req req=%b addr=%h be=%h exp 1/100/f", dm_req, dm_addr, dm_be); end
        dm_ack = 1'b1; dm_rdata = 32'h11223344;
        tick();
        dm_ack = 1'b0; exec_valid = 1'b0;
        tests++; if (ms_load !== 32'h11223344 || ms_err !== 1'b0) begin fails++; $display("FAIL mis_data load=%h err=%b exp 11223344/0", ms_load, ms_err); end
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_store_byte();
        test_store_half_both();
        test_load("ldh_s", 32'h202, 2'd1, 1'b1, 32'h8001FFFF, 4'b1100, 32'hFFFF8001);
        test_load("ldh_u", 32'h202, 2'd1, 1'b0, 32'h8001FFFF, 4'b1100, 32'h00008001);
        test_load("ldb_s", 32'h001, 2'd0, 1'b1, 32'h00008000, 4'b0010, 32'hFFFFFF80);
        test_load("ldb_u", 32'h003, 2'd0, 1'b0, 32'hA5000000, 4'b1000, 32'h000000A5);
        test_timeout();
        test_reset_mid_wait();
        test_misalign();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
